// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, NOP word, widths and the
// jump/branch target arithmetic used by both the fetch stage and the branch unit.
package cpu_pkg;

  localparam int CPU_ADDR_W = 32;
  localparam int CPU_DATA_W = 32;
  localparam logic [CPU_DATA_W-1:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HALTED
  } fetch_state_t;

  // The jump keeps the upper nibble of the sequential PC (same 256 MB region).
  function automatic logic [CPU_ADDR_W-1:0] calc_jump_target(
    input logic [CPU_ADDR_W-1:0] pc_plus4,
    input logic [25:0]           index
  );
    return {pc_plus4[CPU_ADDR_W-1:28], index, 2'b00};
  endfunction

  function automatic logic [CPU_ADDR_W-1:0] calc_branch_target(
    input logic [CPU_ADDR_W-1:0] pc_plus4,
    input logic [15:0]           offset
  );
    return pc_plus4 + {{(CPU_ADDR_W-18){offset[15]}}, offset, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump beats branch beats sequential.
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              br_taken,
  input  logic [15:0]       br_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] jump_pc;
  logic [ADDR_W-1:0] branch_pc;

  assign pc_plus4 = pc + ADDR_W'(4);

  // Reuse the shared target functions whenever the width matches the CPU.
  if (ADDR_W == CPU_ADDR_W) begin : g_pkg_targets
    assign jump_pc   = calc_jump_target(pc_plus4, jump_target);
    assign branch_pc = calc_branch_target(pc_plus4, br_offset);
  end else begin : g_generic_targets
    assign jump_pc   = {pc_plus4[ADDR_W-1:28], jump_target, 2'b00};
    assign branch_pc = pc_plus4 + {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};
  end

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_pc;
    end else if (br_taken) begin
      next_pc = branch_pc;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// PC register and instruction-fetch FSM driven by a PC-phase clock enable,
// with a req/valid handshake to instruction memory and a bounded wait.
module pc_fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                TIMEOUT  = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              br_taken,
  input  logic [15:0]       br_offset,
  input  logic              jump,
  input  logic [25:0]       jump_target,
  input  logic              halt,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_busy,
  output logic              fetch_err,
  output logic              overrun
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  fetch_state_t      state_reg;
  logic              first_reg;
  logic              halt_seen_reg;
  logic [7:0]        wait_cnt_reg;
  logic [ADDR_W-1:0] next_pc;

  next_pc_calc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .pc         (pc),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jump       (jump),
    .jump_target(jump_target),
    .pc_plus4   (pc_plus4),
    .next_pc    (next_pc)
  );

  assign fetch_busy = (state_reg == ST_REQ) || (state_reg == ST_WAIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      first_reg     <= 1'b1;
      halt_seen_reg <= 1'b0;
      wait_cnt_reg  <= '0;
      pc            <= RESET_PC;
      imem_req      <= 1'b0;
      imem_addr     <= RESET_PC;
      instr         <= DATA_W'(NOP);
      instr_valid   <= 1'b0;
      fetch_err     <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (halt) begin
            state_reg <= ST_HALTED;
          end else if (pc_en) begin
            // The very first strobe fetches the reset PC itself.
            first_reg     <= 1'b0;
            halt_seen_reg <= 1'b0;
            instr_valid   <= 1'b0;
            imem_req      <= 1'b1;
            state_reg     <= ST_REQ;
            if (first_reg) begin
              imem_addr <= pc;
            end else begin
              pc        <= next_pc;
              imem_addr <= next_pc;
            end
          end
        end

        ST_REQ: begin
          imem_req     <= 1'b0;
          wait_cnt_reg <= '0;
          state_reg    <= ST_WAIT;
          if (halt)  halt_seen_reg <= 1'b1;
          if (pc_en) overrun       <= 1'b1;
        end

        ST_WAIT: begin
          if (halt)  halt_seen_reg <= 1'b1;
          if (pc_en) overrun       <= 1'b1;
          // Returned data takes precedence over a coincident timeout.
          if (imem_valid || (wait_cnt_reg == WAIT_LAST)) begin
            instr       <= imem_valid ? imem_rdata : DATA_W'(NOP);
            instr_valid <= 1'b1;
            if (!imem_valid) fetch_err <= 1'b1;
            state_reg   <= (halt_seen_reg || halt) ? ST_HALTED : ST_IDLE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end

        ST_HALTED: begin
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench: the driver pushes each fetch's expected result into a
// scoreboard queue; a monitor pops and compares on every rising instr_valid.
module tb_pc_fetch_stage;

  localparam int TIMEOUT = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        pc_en;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        jump;
  logic [25:0] jump_target;
  logic        halt;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fetch_err;
  logic        overrun;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic iv_prev = 1'b0;

  always #5 clock = ~clock;

  pc_fetch_stage #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .RESET_PC(32'h0),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pc_en      (pc_en),
    .br_taken   (br_taken),
    .br_offset  (br_offset),
    .jump       (jump),
    .jump_target(jump_target),
    .halt       (halt),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err),
    .overrun    (overrun)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pc"}, pc, 32'h0);
    check({tag, "_pc_plus4"}, pc_plus4, 32'h4);
    check({tag, "_imem_addr"}, imem_addr, 32'h0);
    check({tag, "_instr"}, instr, 32'h0);
    check_bit({tag, "_imem_req"}, imem_req, 1'b0);
    check_bit({tag, "_instr_valid"}, instr_valid, 1'b0);
    check_bit({tag, "_fetch_busy"}, fetch_busy, 1'b0);
    check_bit({tag, "_fetch_err"}, fetch_err, 1'b0);
    check_bit({tag, "_overrun"}, overrun, 1'b0);
  endtask

  // dly = WAIT cycle on which imem_valid is driven (0 = never, forcing a timeout).
  task automatic fetch(input logic br, input logic [15:0] off, input logic jmp,
                       input logic [25:0] tgt, input logic [31:0] exp_pc,
                       input logic [31:0] data, input int dly, input logic exp_err,
                       input int pen_k, input int halt_k);
    int  waits;
    bit  done;
    sb.push_back('{exp_pc, (dly == 0) ? 32'h0 : data, exp_err});
    @(negedge clock);
    pc_en = 1'b1; br_taken = br; br_offset = off; jump = jmp; jump_target = tgt;
    @(negedge clock);
    pc_en = 1'b0; br_taken = 1'b0; br_offset = '0; jump = 1'b0; jump_target = '0;
    check_bit("req_pulse", imem_req, 1'b1);
    check("req_addr", imem_addr, exp_pc);
    waits = 0;
    done  = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clock);
      if (!fetch_busy) begin
        done = 1'b1;
      end else begin
        waits++;
        if (k == 1) check_bit("req_one_cycle", imem_req, 1'b0);
        imem_valid = (k == dly);
        imem_rdata = (k == dly) ? data : 32'hDEAD_BEEF;
        pc_en      = (k == pen_k);
        halt       = (k == halt_k);
      end
    end
    imem_valid = 1'b0; imem_rdata = '0; pc_en = 1'b0; halt = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL fetch_bound: got busy after 60 cycles expected idle");
    end
    check("wait_cycles", waits, (dly == 0) ? TIMEOUT : dly);
  endtask

  always @(negedge clock) begin
    if (instr_valid && !iv_prev) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_fetch: got pc %h expected no completion", pc);
      end else begin
        check("mon_pc", pc, sb[0].pc);
        check("mon_instr", instr, sb[0].instr);
        check_bit("mon_err", fetch_err, sb[0].err);
        $display("fetch done pc=%h instr=%h err=%0b", pc, instr, fetch_err);
        sb.pop_front();
      end
    end
    iv_prev <= instr_valid;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_en = 1'b0; br_taken = 1'b0; br_offset = '0; jump = 1'b0;
    jump_target = '0; halt = 1'b0; imem_rdata = '0; imem_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset("rst");

    fetch(1'b0, 16'h0000, 1'b0, 26'h0, 32'h0000_0000, 32'h2001_0005, 2, 1'b0, 0, 0);
    fetch(1'b0, 16'h0000, 1'b0, 26'h0, 32'h0000_0004, 32'h8C22_0004, 1, 1'b0, 0, 0);
    fetch(1'b1, 16'hFFFE, 1'b0, 26'h0, 32'h0000_0000, 32'h1000_FFFE, 3, 1'b0, 0, 0);
    fetch(1'b1, 16'h0005, 1'b1, 26'h40, 32'h0000_0100, 32'h0800_0040, 1, 1'b0, 0, 0);
    fetch(1'b0, 16'h0000, 1'b0, 26'h0, 32'h0000_0104, 32'h2222_0001, TIMEOUT, 1'b0, 0, 0);
    fetch(1'b0, 16'h0000, 1'b0, 26'h0, 32'h0000_0108, 32'h0, 0, 1'b1, 0, 0);
    fetch(1'b0, 16'h0000, 1'b0, 26'h0, 32'h0000_010C, 32'h3333_0002, 2, 1'b1, 0, 0);
    fetch(1'b0, 16'h0000, 1'b0, 26'h0, 32'h0000_0110, 32'h4444_0003, 3, 1'b1, 1, 0);
    check_bit("overrun_set", overrun, 1'b1);
    check("overrun_pc", pc, 32'h0000_0110);

    // Reset during WAIT, then a late imem_valid that must be ignored.
    @(negedge clock); pc_en = 1'b1;
    @(negedge clock); pc_en = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0; imem_valid = 1'b1; imem_rdata = 32'h5555_AAAA;
    @(negedge clock); imem_valid = 1'b0; imem_rdata = '0;
    check_reset("abort");
    @(negedge clock);
    check_reset("abort2");

    fetch(1'b0, 16'h0000, 1'b0, 26'h0, 32'h0000_0000, 32'h0000_0020, 1, 1'b0, 0, 0);
    fetch(1'b1, 16'hFFFE, 1'b0, 26'h0, 32'hFFFF_FFFC, 32'h0000_0001, 1, 1'b0, 0, 0);
    fetch(1'b0, 16'h0000, 1'b0, 26'h0, 32'h0000_0000, 32'h0000_0002, 1, 1'b0, 0, 0);
    fetch(1'b0, 16'h0000, 1'b0, 26'h0, 32'h0000_0004, 32'hCAFE_0004, 3, 1'b0, 0, 1);

    // HALTED: strobes are ignored without flagging overrun.
    @(negedge clock); pc_en = 1'b1; jump = 1'b1; jump_target = 26'h123;
    @(negedge clock); pc_en = 1'b0; jump = 1'b0; jump_target = '0;
    for (int i = 0; i < 4; i++) begin
      check_bit("halted_no_req", imem_req, 1'b0);
      @(negedge clock);
    end
    check_bit("halted_busy", fetch_busy, 1'b0);
    check("halted_pc", pc, 32'h0000_0004);
    check("halted_instr", instr, 32'hCAFE_0004);
    check_bit("halted_valid", instr_valid, 1'b1);
    check_bit("halted_overrun", overrun, 1'b0);

    // halt and pc_en together in IDLE: halt wins, nothing is fetched.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock); halt = 1'b1; pc_en = 1'b1;
    @(negedge clock); halt = 1'b0; pc_en = 1'b0;
    check_bit("halt_wins_req", imem_req, 1'b0);
    check_bit("halt_wins_busy", fetch_busy, 1'b0);
    @(negedge clock); pc_en = 1'b1;
    @(negedge clock); pc_en = 1'b0;
    check_bit("halt_wins_req2", imem_req, 1'b0);
    check_bit("halt_wins_overrun", overrun, 1'b0);
    check("halt_wins_addr", imem_addr, 32'h0);

    @(negedge clock);
    check("sb_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
Program-counter and instruction-fetch stage for the single-cycle CPU. It replaces the derived PC and instruction-memory clocks with clock-enable strobes on the single system clock. On each PC-phase strobe it computes the next PC (sequential, branch or jump), requests the instruction from instruction memory with a req/valid handshake, and presents the latched instruction to decode/register stages.

Parameters:
ADDR_W, 32, PC and instruction-memory address width (bits)
DATA_W, 32, instruction width
RESET_PC, 0, PC value loaded at reset; must be word aligned
TIMEOUT, 15, max cycles in WAIT before a fetch is abandoned (1..255)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
pc_en  in  1  one-cycle PC-phase strobe; starts a PC update + fetch
br_taken  in  1  branch taken, sampled with pc_en
br_offset  in  16  signed word offset, sampled with pc_en
jump  in  1  jump, sampled with pc_en; priority over br_taken
jump_target  in  26  word index for jump, sampled with pc_en
halt  in  1  stop fetching after the current fetch
imem_rdata  in  DATA_W  instruction from memory
imem_valid  in  1  imem_rdata valid (one cycle)
imem_req  out  1  one-cycle fetch request
imem_addr  out  ADDR_W  fetch address, stable from REQ until return to IDLE
pc  out  ADDR_W  current PC
pc_plus4  out  ADDR_W  pc + 4, combinational
instr  out  DATA_W  latched instruction
instr_valid  out  1  instr holds a fetched word for the current pc
fetch_busy  out  1  high in REQ and WAIT
fetch_err  out  1  sticky: a fetch timed out
overrun  out  1  sticky: pc_en arrived when not IDLE

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All registers update on the rising edge of clock.
- Reset values: pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr=0 (NOP), instr_valid=0, fetch_err=0, overrun=0, state=IDLE, first=1, timeout counter=0. Reset mid-fetch aborts immediately; any later imem_valid is ignored.
- States: IDLE, REQ, WAIT, HALTED.
- IDLE + pc_en:
  - If first=1: pc is unchanged and first clears.
  - Else pc <= next_pc, with priority jump > br_taken > sequential:
    - jump: {pc_plus4[ADDR_W-1:28], jump_target, 2'b00}
    - branch: pc_plus4 + (sext(br_offset) << 2), modulo 2^ADDR_W (wraps)
    - sequential: pc_plus4, wraps at 2^ADDR_W
  - instr_valid <= 0; imem_addr <= new pc; go to REQ.
- REQ: imem_req=1 for exactly this cycle; counter cleared; go to WAIT.
- WAIT:
  - imem_valid: instr <= imem_rdata, instr_valid <= 1, go to IDLE (or HALTED if halt was seen).
  - Counter reaching TIMEOUT without valid: instr <= 0, instr_valid <= 1, fetch_err <= 1, then same exit as above.
  - imem_valid in the same cycle as the timeout: data wins and no error is flagged.
- imem_valid outside WAIT is ignored.
- pc_en outside IDLE is ignored, and overrun <= 1 (except in HALTED, where it is silently ignored).
- halt:
  - In IDLE: go to HALTED the next cycle. If pc_en arrives in the same cycle, halt wins and no fetch starts.
  - In REQ or WAIT: latched, and takes effect once the fetch completes.
  - HALTED holds pc and instr; only reset exits.
- Latency: pc_en to imem_req is 1 cycle; imem_valid to instr_valid is 1 cycle.
- Address bits [1:0] are always 0.

Decomposition:
- Shared package cpu_pkg: state encoding, NOP constant (32'h0), instruction/address widths, and the jump/branch target functions (these are shared with the branch unit).
- One natural sub-module: next_pc_calc (combinational next-PC mux and adders). The FSM stays in the top module.

Test Plan:
- Reset, pc_en, imem_valid on the 2nd WAIT cycle with 32'h2001_0005 -> imem_addr=0 and imem_req 1 cycle after pc_en; instr=32'h2001_0005 and instr_valid=1 one cycle later; pc=0.
- Sequential then branch: after the first fetch, pc_en plain -> pc=4; pc_en with br_taken, br_offset=-2 -> pc=4+4-8=0.
- Jump with br_taken also high, jump_target=26'h00_0040 -> pc=32'h0000_0100; the branch is ignored.
- imem_valid never returns -> after TIMEOUT=15 WAIT cycles instr=0, instr_valid=1, fetch_err=1, state IDLE; the next pc_en fetches normally and fetch_err stays 1.
- pc_en asserted during WAIT -> overrun=1, pc unchanged. halt asserted during WAIT -> fetch completes and state becomes HALTED; further pc_en has no effect.
- Reset asserted in WAIT, then imem_valid the next cycle -> all outputs at reset values, instr_valid=0, imem_valid ignored.
